data_bus: RTL and testbench
===========================

DATA_BUS -- requirements
Module: data_bus

Interface
REQ-001 Parameter REG_WIDTH, default 8 (from shared package), width of every data port.
REQ-002 clk  input  1  bus clock; all state updates on rising edge (driven from phi2 at system level).
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 pc_in, sp_in, add_in, x_in, y_in, stat_in  input  REG_WIDTH each  register source values.
REQ-005 mem_in, imm_in, fetch_in, decode_in, alu_in  input  REG_WIDTH each  memory, immediate, fetcher, decoder and ALU source values.
REQ-006 pc_selector, sp_selector, add_selector, x_selector, y_selector, stat_selector  input  4 each  source select for the matching destination.
REQ-007 mem_selector, fetch_selector, decode_selector, alu0_selector, alu1_selector  input  4 each  source select for the matching destination.
REQ-008 pc_out, sp_out, add_out, x_out, y_out, stat_out  output  REG_WIDTH each  destination values to register inputs.
REQ-009 mem_out, fetch_out, decode_out, alu0_out, alu1_out  output  REG_WIDTH each  destination values to memory, fetcher, decoder and both ALU operands.

Function
REQ-010 Selector encoding: 0 NONE, 1 PC, 2 SP, 3 ADD, 4 X, 5 Y, 6 STAT, 7 MEM, 8 IMM, 9 FETCH, 10 DECODE, 11 ALU; 12-15 reserved.
REQ-011 Each destination output is an independent REG_WIDTH flop loaded on each rising clk with the source chosen by its own selector.
REQ-012 Latency: exactly one clk edge from a selector/source change to the output; no combinational path from any input to any output.
REQ-013 Selector NONE or a reserved code loads 0x00 into that output.
REQ-014 Source value passes bit-for-bit unchanged; no arithmetic, extension or masking; X/Z on a selected source (e.g. undriven decode_in) propagates.
REQ-015 Any number of destinations may select the same source in the same cycle; all receive the same value (fan-out, no contention).
REQ-016 A destination may select its own counterpart source (e.g. pc_selector=PC), giving a one-cycle-delayed copy of that input.
REQ-017 Destinations never influence each other; changing one selector affects only its own output.
REQ-018 Module holds no state besides the eleven output flops.

Reset
REQ-019 reset_n low asynchronously forces all eleven outputs to 0x00 immediately, independent of clk.
REQ-020 While reset_n is low, clk edges are ignored and outputs stay 0x00.
REQ-021 First rising clk after reset_n deasserts loads outputs normally per REQ-011; reset mid-operation discards in-flight values.

Structure
REQ-022 Shared package holds REG_WIDTH and the selector code constants (SEL_NONE ... SEL_ALU); the decoder uses the same constants.
REQ-023 One sub-module, bus_port: 11:1 source mux plus async-reset output flop; data_bus instantiates it eleven times, one per destination.
REQ-024 Block size: 120-400 lines RTL including bus_port.

Verification
REQ-025 Reset: drive all sources 0xA5, all selectors to PC, assert reset_n low between edges -> all outputs 0x00 at once and through 3 clk edges.
REQ-026 Routing sweep: sources pc=01, sp=02, add=03, x=04, y=05, stat=06, mem=07, imm=08, fetch=09, alu=0B; step each destination selector 1..11 -> output equals the selected code's value one edge later, not before.
REQ-027 Fan-out: mem_in=3C, all eleven selectors=MEM -> every output 3C after one edge.
REQ-028 NONE/reserved: x_selector=0 then 13 with x_in=FF -> x_out 00 after each edge.
REQ-029 Independence: toggle alu0_selector between X and Y each edge with x_in=11, y_in=22, all others fixed -> only alu0_out alternates 11/22, others unchanged.
REQ-030 Async reset mid-operation: outputs nonzero, reset_n low for half a clk period -> outputs 00 immediately; after release, next edge restores routed values.

Source files
------------

// File: rtl/data_bus_pkg.sv
// ============================================================================
// Module      : data_bus_pkg
// Description : Shared width, selector codes and port indices for data_bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_bus_pkg;

    localparam int REG_WIDTH = 8;
    localparam int N_SRC     = 11;
    localparam int N_DEST    = 11;
    localparam int SEL_WIDTH = 4;

    // Selector codes shared by every destination decoder
    localparam logic [SEL_WIDTH-1:0] SEL_NONE   = 4'd0;
    localparam logic [SEL_WIDTH-1:0] SEL_PC     = 4'd1;
    localparam logic [SEL_WIDTH-1:0] SEL_SP     = 4'd2;
    localparam logic [SEL_WIDTH-1:0] SEL_ADD    = 4'd3;
    localparam logic [SEL_WIDTH-1:0] SEL_X      = 4'd4;
    localparam logic [SEL_WIDTH-1:0] SEL_Y      = 4'd5;
    localparam logic [SEL_WIDTH-1:0] SEL_STAT   = 4'd6;
    localparam logic [SEL_WIDTH-1:0] SEL_MEM    = 4'd7;
    localparam logic [SEL_WIDTH-1:0] SEL_IMM    = 4'd8;
    localparam logic [SEL_WIDTH-1:0] SEL_FETCH  = 4'd9;
    localparam logic [SEL_WIDTH-1:0] SEL_DECODE = 4'd10;
    localparam logic [SEL_WIDTH-1:0] SEL_ALU    = 4'd11;

    // Position of each source inside the packed source bundle
    localparam int SRC_PC     = 0;
    localparam int SRC_SP     = 1;
    localparam int SRC_ADD    = 2;
    localparam int SRC_X      = 3;
    localparam int SRC_Y      = 4;
    localparam int SRC_STAT   = 5;
    localparam int SRC_MEM    = 6;
    localparam int SRC_IMM    = 7;
    localparam int SRC_FETCH  = 8;
    localparam int SRC_DECODE = 9;
    localparam int SRC_ALU    = 10;

    // Position of each destination inside the packed selector/output bundles
    localparam int DST_PC     = 0;
    localparam int DST_SP     = 1;
    localparam int DST_ADD    = 2;
    localparam int DST_X      = 3;
    localparam int DST_Y      = 4;
    localparam int DST_STAT   = 5;
    localparam int DST_MEM    = 6;
    localparam int DST_FETCH  = 7;
    localparam int DST_DECODE = 8;
    localparam int DST_ALU0   = 9;
    localparam int DST_ALU1   = 10;

endpackage

`default_nettype wire

// File: rtl/bus_port.sv
// ============================================================================
// Module      : bus_port
// Description : One bus destination: 11:1 source mux into an async-reset flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_port
    import data_bus_pkg::*;
#(
    parameter int WIDTH = data_bus_pkg::REG_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [SEL_WIDTH-1:0]            sel,
    input  logic [N_SRC-1:0][WIDTH-1:0]     src,
    output logic [WIDTH-1:0]                data
);

    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] r_data;

    // NONE and the reserved codes 12-15 all fall through to zero
    always_comb begin
        w_mux = '0;
        case (sel)
            SEL_PC:     w_mux = src[SRC_PC];
            SEL_SP:     w_mux = src[SRC_SP];
            SEL_ADD:    w_mux = src[SRC_ADD];
            SEL_X:      w_mux = src[SRC_X];
            SEL_Y:      w_mux = src[SRC_Y];
            SEL_STAT:   w_mux = src[SRC_STAT];
            SEL_MEM:    w_mux = src[SRC_MEM];
            SEL_IMM:    w_mux = src[SRC_IMM];
            SEL_FETCH:  w_mux = src[SRC_FETCH];
            SEL_DECODE: w_mux = src[SRC_DECODE];
            SEL_ALU:    w_mux = src[SRC_ALU];
            default:    w_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
        end else begin
            r_data <= w_mux;
        end
    end

    assign data = r_data;

endmodule

`default_nettype wire

// File: rtl/data_bus.sv
// ============================================================================
// Module      : data_bus
// Description : Registered crossbar routing eleven sources to eleven destinations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_bus
    import data_bus_pkg::*;
#(
    parameter int REG_WIDTH = data_bus_pkg::REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic [REG_WIDTH-1:0] pc_in,
    input  logic [REG_WIDTH-1:0] sp_in,
    input  logic [REG_WIDTH-1:0] add_in,
    input  logic [REG_WIDTH-1:0] x_in,
    input  logic [REG_WIDTH-1:0] y_in,
    input  logic [REG_WIDTH-1:0] stat_in,
    input  logic [REG_WIDTH-1:0] mem_in,
    input  logic [REG_WIDTH-1:0] imm_in,
    input  logic [REG_WIDTH-1:0] fetch_in,
    input  logic [REG_WIDTH-1:0] decode_in,
    input  logic [REG_WIDTH-1:0] alu_in,

    input  logic [3:0]           pc_selector,
    input  logic [3:0]           sp_selector,
    input  logic [3:0]           add_selector,
    input  logic [3:0]           x_selector,
    input  logic [3:0]           y_selector,
    input  logic [3:0]           stat_selector,
    input  logic [3:0]           mem_selector,
    input  logic [3:0]           fetch_selector,
    input  logic [3:0]           decode_selector,
    input  logic [3:0]           alu0_selector,
    input  logic [3:0]           alu1_selector,

    output logic [REG_WIDTH-1:0] pc_out,
    output logic [REG_WIDTH-1:0] sp_out,
    output logic [REG_WIDTH-1:0] add_out,
    output logic [REG_WIDTH-1:0] x_out,
    output logic [REG_WIDTH-1:0] y_out,
    output logic [REG_WIDTH-1:0] stat_out,
    output logic [REG_WIDTH-1:0] mem_out,
    output logic [REG_WIDTH-1:0] fetch_out,
    output logic [REG_WIDTH-1:0] decode_out,
    output logic [REG_WIDTH-1:0] alu0_out,
    output logic [REG_WIDTH-1:0] alu1_out
);

    logic [N_SRC-1:0][REG_WIDTH-1:0]  w_src;
    logic [N_DEST-1:0][SEL_WIDTH-1:0] w_sel;
    logic [N_DEST-1:0][REG_WIDTH-1:0] w_dout;

    assign w_src[SRC_PC]     = pc_in;
    assign w_src[SRC_SP]     = sp_in;
    assign w_src[SRC_ADD]    = add_in;
    assign w_src[SRC_X]      = x_in;
    assign w_src[SRC_Y]      = y_in;
    assign w_src[SRC_STAT]   = stat_in;
    assign w_src[SRC_MEM]    = mem_in;
    assign w_src[SRC_IMM]    = imm_in;
    assign w_src[SRC_FETCH]  = fetch_in;
    assign w_src[SRC_DECODE] = decode_in;
    assign w_src[SRC_ALU]    = alu_in;

    assign w_sel[DST_PC]     = pc_selector;
    assign w_sel[DST_SP]     = sp_selector;
    assign w_sel[DST_ADD]    = add_selector;
    assign w_sel[DST_X]      = x_selector;
    assign w_sel[DST_Y]      = y_selector;
    assign w_sel[DST_STAT]   = stat_selector;
    assign w_sel[DST_MEM]    = mem_selector;
    assign w_sel[DST_FETCH]  = fetch_selector;
    assign w_sel[DST_DECODE] = decode_selector;
    assign w_sel[DST_ALU0]   = alu0_selector;
    assign w_sel[DST_ALU1]   = alu1_selector;

    // Every destination sees the full source bundle, so fan-out needs no arbitration
    for (genvar d = 0; d < N_DEST; d++) begin : g_port
        bus_port #(
            .WIDTH   (REG_WIDTH)
        ) u_port (
            .clk     (clk),
            .reset_n (reset_n),
            .sel     (w_sel[d]),
            .src     (w_src),
            .data    (w_dout[d])
        );
    end

    assign pc_out     = w_dout[DST_PC];
    assign sp_out     = w_dout[DST_SP];
    assign add_out    = w_dout[DST_ADD];
    assign x_out      = w_dout[DST_X];
    assign y_out      = w_dout[DST_Y];
    assign stat_out   = w_dout[DST_STAT];
    assign mem_out    = w_dout[DST_MEM];
    assign fetch_out  = w_dout[DST_FETCH];
    assign decode_out = w_dout[DST_DECODE];
    assign alu0_out   = w_dout[DST_ALU0];
    assign alu1_out   = w_dout[DST_ALU1];

endmodule

`default_nettype wire

// File: tb/tb_data_bus.sv
// ============================================================================
// Module      : tb_data_bus
// Description : Directed vector bench for data_bus routing, latency and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_bus;

    // Source index order: pc sp add x y stat mem imm fetch decode alu
    // Destination order:  pc sp add x y stat mem fetch decode alu0 alu1
    typedef struct {
        logic [10:0][7:0] src;
        logic [10:0][3:0] sel;
        logic [10:0][7:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [10:0][7:0] src;
    logic [10:0][3:0] sel;
    logic [10:0][7:0] outs;
    logic [10:0][7:0] prev;

    int n_tests = 0;
    int n_fail  = 0;

    string dname [11] = '{"pc", "sp", "add", "x", "y", "stat", "mem", "fetch", "decode", "alu0", "alu1"};

    always #5 clk = ~clk;

    data_bus dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pc_in           (src[0]),
        .sp_in           (src[1]),
        .add_in          (src[2]),
        .x_in            (src[3]),
        .y_in            (src[4]),
        .stat_in         (src[5]),
        .mem_in          (src[6]),
        .imm_in          (src[7]),
        .fetch_in        (src[8]),
        .decode_in       (src[9]),
        .alu_in          (src[10]),
        .pc_selector     (sel[0]),
        .sp_selector     (sel[1]),
        .add_selector    (sel[2]),
        .x_selector      (sel[3]),
        .y_selector      (sel[4]),
        .stat_selector   (sel[5]),
        .mem_selector    (sel[6]),
        .fetch_selector  (sel[7]),
        .decode_selector (sel[8]),
        .alu0_selector   (sel[9]),
        .alu1_selector   (sel[10]),
        .pc_out          (outs[0]),
        .sp_out          (outs[1]),
        .add_out         (outs[2]),
        .x_out           (outs[3]),
        .y_out           (outs[4]),
        .stat_out        (outs[5]),
        .mem_out         (outs[6]),
        .fetch_out       (outs[7]),
        .decode_out      (outs[8]),
        .alu0_out        (outs[9]),
        .alu1_out        (outs[10])
    );

    // Arguments listed in destination/source order, index 0 first
    function automatic logic [10:0][3:0] s11(input logic [3:0] a0, a1, a2, a3, a4, a5,
                                             a6, a7, a8, a9, a10);
        return {a10, a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [10:0][7:0] v11(input logic [7:0] a0, a1, a2, a3, a4, a5,
                                             a6, a7, a8, a9, a10);
        return {a10, a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [10:0][7:0] fill8(input logic [7:0] v);
        return {11{v}};
    endfunction

    task automatic check_all(input string tag, input logic [10:0][7:0] exp);
        for (int d = 0; d < 11; d++) begin
            n_tests++;
            if (outs[d] !== exp[d]) begin
                n_fail++;
                $display("FAIL %s %s_out: got %h expected %h", tag, dname[d], outs[d], exp[d]);
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [10:0][7:0] base;
        logic [10:0][7:0] indep_src;
        logic [10:0][3:0] indep_sel;
        vec_t v;

        base = v11(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                   8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B);

        // Routing sweep: one destination at a time, codes 1..11; base value equals its code
        for (int d = 0; d < 11; d++) begin
            for (int s = 1; s <= 11; s++) begin
                v.src    = base;
                v.sel    = '0;
                v.sel[d] = 4'(s);
                v.exp    = '0;
                v.exp[d] = 8'(s);
                vecs.push_back(v);
            end
        end

        // Fan-out of mem_in to every destination
        v.src    = base;
        v.src[6] = 8'h3C;
        v.sel    = {11{4'd7}};
        v.exp    = fill8(8'h3C);
        vecs.push_back(v);

        // NONE and reserved codes on x with x_in=FF, reserved codes elsewhere too
        v.src    = base;
        v.src[3] = 8'hFF;
        v.sel    = s11(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        v.exp    = '0;
        vecs.push_back(v);
        v.sel    = s11(4'd12, 4'd14, 4'd15, 4'd13, 4'd12, 4'd13, 4'd14, 4'd15, 4'd12, 4'd13, 4'd4);
        v.exp    = v11(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        vecs.push_back(v);

        // Independence: alu0 toggles X/Y while everything else holds its routing
        indep_src    = base;
        indep_src[3] = 8'h11;
        indep_src[4] = 8'h22;
        indep_sel = s11(4'd2, 4'd3, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd1, 4'd7, 4'd4, 4'd0);
        for (int k = 0; k < 4; k++) begin
            v.src     = indep_src;
            v.sel     = indep_sel;
            v.sel[9]  = (k % 2 == 0) ? 4'd4 : 4'd5;
            v.exp     = v11(8'h02, 8'h03, 8'h06, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h01, 8'h07,
                            (k % 2 == 0) ? 8'h11 : 8'h22, 8'h00);
            vecs.push_back(v);
        end

        // ---------------- reset behaviour ----------------
        src     = fill8(8'hA5);
        sel     = {11{4'd1}};
        reset_n = 1'b0;
        #1;
        check_all("reset_at_start", '0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_held", '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("first_edge_after_release", fill8(8'hA5));

        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_reset_immediate", '0);
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("reset_edge%0d", e), '0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("reload_after_reset", fill8(8'hA5));
        prev = fill8(8'hA5);

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            src = vecs[i].src;
            sel = vecs[i].sel;
            #1;
            check_all($sformatf("vec%0d_before_edge", i), prev);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp);
            prev = vecs[i].exp;
        end

        // ---------------- async reset mid-operation ----------------
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("midop_reset_immediate", '0);
        #4;
        reset_n = 1'b1;
        #1;
        check_all("midop_reset_released", '0);
        @(posedge clk);
        #1;
        check_all("midop_restore", prev);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
